// File: rtl/mcu_subsys_pkg.sv
// Shared types and constants for the MCU subsystem bus fabric.
package mcu_subsys_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_SRAM, TGT_PERIPH} tgt_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    localparam logic [31:0] BUS_ERR_RDATA    = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_SRAM_BASE    = 32'h0000_0000;
    localparam int          DEF_SRAM_AW      = 16;
    localparam logic [31:0] DEF_PERIPH_BASE  = 32'h4000_0000;
    localparam int          DEF_PERIPH_AW    = 16;

    // Low-bit mask of a 2**aw byte window.
    function automatic logic [31:0] win_mask(input int aw);
        return (aw >= 32) ? '1 : ((32'h1 << aw) - 32'h1);
    endfunction

endpackage

// File: rtl/mcu_subsys_addr_decode.sv
// Combinational window decode: byte address -> target and in-window offset.
module mcu_subsys_addr_decode
    import mcu_subsys_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE   = DEF_SRAM_BASE,
    parameter int          SRAM_AW     = DEF_SRAM_AW,
    parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE,
    parameter int          PERIPH_AW   = DEF_PERIPH_AW
) (
    input  logic [31:0] addr,
    output tgt_t        tgt,
    output logic [31:0] offset
);

    localparam logic [31:0] SRAM_MASK   = win_mask(SRAM_AW);
    localparam logic [31:0] PERIPH_MASK = win_mask(PERIPH_AW);

    // SRAM is tested first so an overlapping misconfiguration resolves to SRAM.
    always_comb begin
        tgt    = TGT_NONE;
        offset = '0;
        if ((addr & ~SRAM_MASK) == SRAM_BASE) begin
            tgt    = TGT_SRAM;
            offset = addr & SRAM_MASK;
        end else if ((addr & ~PERIPH_MASK) == PERIPH_BASE) begin
            tgt    = TGT_PERIPH;
            offset = addr & PERIPH_MASK;
        end
    end

endmodule

// File: rtl/mcu_subsys_bus_decoder.sv
// CPU native-port decoder to SRAM / peripheral window with registered request stage.
// Optional target wait timeout enabled by defining MCU_BUS_TIMEOUT_EN.
module mcu_subsys_bus_decoder
    import mcu_subsys_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE      = DEF_SRAM_BASE,
    parameter int          SRAM_AW        = DEF_SRAM_AW,
    parameter logic [31:0] PERIPH_BASE    = DEF_PERIPH_BASE,
    parameter int          PERIPH_AW      = DEF_PERIPH_AW,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_mem_valid,
    output logic        cpu_mem_ready,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic [31:0] cpu_mem_rdata,
    output logic        sram_mem_valid,
    input  logic        sram_mem_ready,
    output logic [31:0] sram_mem_addr,
    output logic [31:0] sram_mem_wdata,
    output logic [3:0]  sram_mem_wstrb,
    input  logic [31:0] sram_mem_rdata,
    output logic        per_mem_valid,
    input  logic        per_mem_ready,
    output logic [31:0] per_mem_addr,
    output logic [31:0] per_mem_wdata,
    output logic [3:0]  per_mem_wstrb,
    input  logic [31:0] per_mem_rdata,
    output logic        bus_err,
    output logic [31:0] bus_err_addr,
    input  logic        bus_err_clr
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_q, state_d;
    tgt_t        tgt_q, dec_tgt;
    mem_req_t    req_q;
    logic [31:0] dec_off;
    logic        acc_ready;
    logic [31:0] acc_rdata;
    logic        timeout;
    logic        err_evt;
    logic [31:0] err_addr_d;

    mcu_subsys_addr_decode #(
        .SRAM_BASE  (SRAM_BASE),
        .SRAM_AW    (SRAM_AW),
        .PERIPH_BASE(PERIPH_BASE),
        .PERIPH_AW  (PERIPH_AW)
    ) u_dec (
        .addr  (cpu_mem_addr),
        .tgt   (dec_tgt),
        .offset(dec_off)
    );

    assign acc_ready = (tgt_q == TGT_PERIPH) ? per_mem_ready : sram_mem_ready;
    assign acc_rdata = (tgt_q == TGT_PERIPH) ? per_mem_rdata : sram_mem_rdata;

`ifdef MCU_BUS_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
    logic [31:0] cpu_addr_q;

    // Counter value equals the number of ACCESS cycles already spent without ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            cpu_addr_q <= '0;
        end else begin
            if (state_q != ACCESS)
                wait_cnt <= '0;
            else if (!acc_ready)
                wait_cnt <= wait_cnt + 16'd1;
            if (state_q == IDLE && cpu_mem_valid)
                cpu_addr_q <= cpu_mem_addr;
        end
    end

    assign timeout = (state_q == ACCESS) && !acc_ready && (wait_cnt == WAIT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        err_evt    = 1'b0;
        err_addr_d = cpu_mem_addr;
        case (state_q)
            IDLE: if (cpu_mem_valid) begin
                state_d = (dec_tgt == TGT_NONE) ? RESP : ACCESS;
                err_evt = (dec_tgt == TGT_NONE);
            end
            ACCESS: if (acc_ready || timeout) begin
                state_d = RESP;
                err_evt = timeout;
`ifdef MCU_BUS_TIMEOUT_EN
                err_addr_d = cpu_addr_q;
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tgt_q         <= TGT_NONE;
            req_q         <= '0;
            cpu_mem_ready <= 1'b0;
            cpu_mem_rdata <= '0;
            bus_err       <= 1'b0;
            bus_err_addr  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpu_mem_valid) begin
                tgt_q <= dec_tgt;
                req_q <= '{addr: dec_off, wdata: cpu_mem_wdata, wstrb: cpu_mem_wstrb};
            end
            cpu_mem_ready <= (state_d == RESP);
            cpu_mem_rdata <= (state_d != RESP) ? '0 : (err_evt ? BUS_ERR_RDATA : acc_rdata);
            // A fresh error beats a simultaneous clear and re-arms the address capture.
            if (err_evt) begin
                bus_err <= 1'b1;
                if (!bus_err || bus_err_clr)
                    bus_err_addr <= err_addr_d;
            end else if (bus_err_clr) begin
                bus_err      <= 1'b0;
                bus_err_addr <= '0;
            end
        end
    end

    assign sram_mem_valid = (state_q == ACCESS) && (tgt_q == TGT_SRAM);
    assign per_mem_valid  = (state_q == ACCESS) && (tgt_q == TGT_PERIPH);
    assign sram_mem_addr  = req_q.addr;
    assign sram_mem_wdata = req_q.wdata;
    assign sram_mem_wstrb = req_q.wstrb;
    assign per_mem_addr   = req_q.addr;
    assign per_mem_wdata  = req_q.wdata;
    assign per_mem_wstrb  = req_q.wstrb;

endmodule

// File: tb/tb_mcu_subsys_bus_decoder.sv
// Randomised self-checking bench: transaction-level model predicts per-cycle outputs.
module tb_mcu_subsys_bus_decoder;

    localparam int TO = 8;
`ifdef MCU_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int STUCK_CYC = 3;
`else
    localparam bit TO_EN = 1'b0;
    localparam int STUCK_CYC = 100;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cpu_mem_valid = 1'b0, cpu_mem_ready;
    logic [31:0] cpu_mem_addr = '0, cpu_mem_wdata = '0, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb = '0;
    logic        sram_mem_valid, sram_mem_ready = 1'b0;
    logic [31:0] sram_mem_addr, sram_mem_wdata, sram_mem_rdata = '0;
    logic [3:0]  sram_mem_wstrb;
    logic        per_mem_valid, per_mem_ready = 1'b0;
    logic [31:0] per_mem_addr, per_mem_wdata, per_mem_rdata = '0;
    logic [3:0]  per_mem_wstrb;
    logic        bus_err, bus_err_clr = 1'b0;
    logic [31:0] bus_err_addr;

    mcu_subsys_bus_decoder #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_rdata(cpu_mem_rdata),
        .sram_mem_valid(sram_mem_valid), .sram_mem_ready(sram_mem_ready),
        .sram_mem_addr(sram_mem_addr), .sram_mem_wdata(sram_mem_wdata),
        .sram_mem_wstrb(sram_mem_wstrb), .sram_mem_rdata(sram_mem_rdata),
        .per_mem_valid(per_mem_valid), .per_mem_ready(per_mem_ready),
        .per_mem_addr(per_mem_addr), .per_mem_wdata(per_mem_wdata),
        .per_mem_wstrb(per_mem_wstrb), .per_mem_rdata(per_mem_rdata),
        .bus_err(bus_err), .bus_err_addr(bus_err_addr), .bus_err_clr(bus_err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Transaction model: accept edge m_n, response cycle m_r (cyc index after an edge).
    bit          m_act = 1'b0, m_iserr = 1'b0, m_chkrd = 1'b0;
    int          m_n = 0, m_r = 0, m_w = 0, m_tgt = 0;
    logic [31:0] m_addr = '0, m_off = '0, m_wdata = '0, m_rdata = '0, m_pdata = '0;
    logic [3:0]  m_wstrb = '0;
    bit          e_err = 1'b0;
    logic [31:0] e_addr = '0;

    logic [31:0] ref_mem   [0:16383];
    logic [31:0] slave_mem [0:16383];

    // Target models: ready from the chosen wait count, garbage rdata when not ready.
    always @(negedge clk) begin
        logic rs, rp;
        rs = m_act && m_tgt == 1 && m_w >= 0 && cyc >= m_n + m_w;
        rp = m_act && m_tgt == 2 && m_w >= 0 && cyc >= m_n + m_w;
        sram_mem_ready = rs;
        per_mem_ready  = rp;
        sram_mem_rdata = rs ? slave_mem[sram_mem_addr[15:2]] : $urandom;
        per_mem_rdata  = rp ? m_pdata : $urandom;
        if (rs && sram_mem_valid)
            for (int b = 0; b < 4; b++)
                if (sram_mem_wstrb[b]) slave_mem[sram_mem_addr[15:2]][8*b +: 8] = sram_mem_wdata[8*b +: 8];
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            chk("rst_sram_valid", {31'd0, sram_mem_valid}, 32'd0);
            chk("rst_per_valid",  {31'd0, per_mem_valid}, 32'd0);
            chk("rst_ready",      {31'd0, cpu_mem_ready}, 32'd0);
            chk("rst_rdata",      cpu_mem_rdata, 32'd0);
            chk("rst_bus_err",    {31'd0, bus_err}, 32'd0);
            chk("rst_err_addr",   bus_err_addr, 32'd0);
        end else begin
            bit exp_rdy, exp_sv, exp_pv;
            if (m_act && m_iserr && cyc == m_r) begin
                if (!e_err || bus_err_clr) e_addr = m_addr;
                e_err = 1'b1;
            end else if (bus_err_clr) begin
                e_err  = 1'b0;
                e_addr = '0;
            end
            exp_rdy = m_act && cyc == m_r;
            exp_sv  = m_act && m_tgt == 1 && cyc >= m_n && cyc < m_r;
            exp_pv  = m_act && m_tgt == 2 && cyc >= m_n && cyc < m_r;
            chk("cpu_ready",  {31'd0, cpu_mem_ready},  {31'd0, exp_rdy});
            chk("sram_valid", {31'd0, sram_mem_valid}, {31'd0, exp_sv});
            chk("per_valid",  {31'd0, per_mem_valid},  {31'd0, exp_pv});
            if (!exp_rdy)     chk("rdata_idle", cpu_mem_rdata, 32'd0);
            else if (m_chkrd) chk("rdata", cpu_mem_rdata, m_rdata);
            if (exp_sv) begin
                chk("sram_addr", sram_mem_addr, m_off);
                chk("sram_wdata", sram_mem_wdata, m_wdata);
                chk("sram_wstrb", {28'd0, sram_mem_wstrb}, {28'd0, m_wstrb});
            end
            if (exp_pv) begin
                chk("per_addr", per_mem_addr, m_off);
                chk("per_wdata", per_mem_wdata, m_wdata);
                chk("per_wstrb", {28'd0, per_mem_wstrb}, {28'd0, m_wstrb});
            end
            chk("bus_err", {31'd0, bus_err}, {31'd0, e_err});
            chk("bus_err_addr", bus_err_addr, e_addr);
        end
    end

    // waits < 0 means the target never answers.
    task automatic start_txn(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input int waits, input logic clr);
        @(negedge clk);
        m_addr  = addr;
        m_off   = addr & 32'h0000_FFFF;
        m_tgt   = (addr[31:16] == 16'h0000) ? 1 : (addr[31:16] == 16'h4000) ? 2 : 0;
        m_n     = cyc + 1;
        m_w     = waits;
        m_wdata = wdata;
        m_wstrb = wstrb;
        m_pdata = $urandom;
        m_iserr = 1'b0;
        m_chkrd = (wstrb == 4'd0);
        if (m_tgt == 0) begin
            m_off = '0; m_iserr = 1'b1; m_chkrd = 1'b1;
            m_r = m_n; m_rdata = 32'hDEAD_BEEF;
        end else if (m_tgt == 2 && TO_EN && (waits < 0 || waits >= TO)) begin
            m_iserr = 1'b1; m_chkrd = 1'b1;
            m_r = m_n + TO; m_rdata = 32'hDEAD_BEEF;
        end else if (waits < 0) begin
            m_r = m_n + 1000000;
        end else begin
            m_r = m_n + 1 + waits;
            m_rdata = (m_tgt == 1) ? ref_mem[m_off[15:2]] : m_pdata;
        end
        if (m_tgt == 1)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) ref_mem[m_off[15:2]][8*b +: 8] = wdata[8*b +: 8];
        cpu_mem_addr  = addr;
        cpu_mem_wdata = wdata;
        cpu_mem_wstrb = wstrb;
        cpu_mem_valid = 1'b1;
        bus_err_clr   = clr;
        m_act = 1'b1;
    endtask

    task automatic wait_done(output logic [31:0] rd, output int lat);
        bit found = 1'b0;
        rd = '0; lat = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            bus_err_clr = 1'b0;
            if (cpu_mem_ready) begin
                found = 1'b1;
                rd  = cpu_mem_rdata;
                lat = cyc - m_n;
            end
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL txn_done: no cpu_mem_ready within 60 cycles for addr %h", m_addr);
        end
        cpu_mem_valid = 1'b0;
        m_act = 1'b0;
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int waits, input logic clr, output logic [31:0] rd, output int lat);
        start_txn(addr, wdata, wstrb, waits, clr);
        wait_done(rd, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_err_clr = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        bus_err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a;
        int lat, k, stuck_rdy;
        for (int i = 0; i < 16384; i++) begin ref_mem[i] = '0; slave_mem[i] = '0; end
        ref_mem[4] = 32'h1234_5678; slave_mem[4] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_txn(32'h0000_0010, '0, 4'b0000, 0, 1'b0, rd, lat);
        chk("sram_rd_lat", lat, 1);
        chk("sram_rd_data", rd, 32'h1234_5678);
        do_txn(32'h0000_0020, 32'hAABB_CCDD, 4'b0010, 0, 1'b0, rd, lat);
        do_txn(32'h0000_0020, '0, 4'b0000, 1, 1'b0, rd, lat);
        chk("sram_bytewr_data", rd, 32'h0000_CC00);
        start_txn(32'h4000_0104, '0, 4'b0000, 3, 1'b0);
        a = m_pdata;
        wait_done(rd, lat);
        chk("per_rd_lat", lat, 4);
        chk("per_rd_data", rd, a);

        do_txn(32'h8000_0000, 32'h1, 4'b0000, 0, 1'b0, rd, lat);
        chk("err1_lat", lat, 0);
        chk("err1_data", rd, 32'hDEAD_BEEF);
        chk("err1_flag", {31'd0, bus_err}, 32'd1);
        chk("err1_addr", bus_err_addr, 32'h8000_0000);
        do_txn(32'h9000_0000, 32'h2, 4'b1111, 0, 1'b0, rd, lat);
        chk("err2_addr_kept", bus_err_addr, 32'h8000_0000);
        do_txn(32'hA000_0000, 32'h3, 4'b0000, 0, 1'b1, rd, lat);
        chk("err3_flag", {31'd0, bus_err}, 32'd1);
        chk("err3_addr", bus_err_addr, 32'hA000_0000);
        @(negedge clk); bus_err_clr = 1'b1;
        @(negedge clk); bus_err_clr = 1'b0;
        chk("err_cleared", {31'd0, bus_err}, 32'd0);

        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            if (k < 5) begin
                a = 32'h0000_0100 + ($urandom_range(0, 255) << 2);
                start_txn(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
                          $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            end else if (k < 8) begin
                a = 32'h4000_0000 | ($urandom_range(0, 16383) << 2);
                start_txn(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
                          TO_EN ? $urandom_range(0, 9) : $urandom_range(0, 5),
                          ($urandom_range(0, 7) == 0));
            end else begin
                case ($urandom_range(0, 3))
                    0: a = 32'h0001_0000;
                    1: a = 32'h3FFF_FFFC;
                    2: a = 32'h4001_0000;
                    default: begin
                        a = $urandom;
                        while (a[31:16] == 16'h0000 || a[31:16] == 16'h4000) a = $urandom;
                    end
                endcase
                start_txn(a, $urandom, 4'($urandom), 0, ($urandom_range(0, 3) == 0));
            end
            wait_done(rd, lat);
            idle($urandom_range(0, 2));
        end

        if (TO_EN) begin
            do_txn(32'h4000_0200, '0, 4'b0000, -1, 1'b0, rd, lat);
            chk("timeout_lat", lat, TO);
            chk("timeout_data", rd, 32'hDEAD_BEEF);
            chk("timeout_flag", {31'd0, bus_err}, 32'd1);
        end
        do_txn(32'hC000_0000, '0, 4'b0000, 0, 1'b0, rd, lat);

        // Stalled peripheral read, then reset while it is in ACCESS.
        start_txn(32'h4000_0300, '0, 4'b0000, -1, 1'b0);
        stuck_rdy = 0;
        repeat (STUCK_CYC) begin
            @(negedge clk);
            if (cpu_mem_ready) stuck_rdy++;
        end
        chk("stuck_no_ready", stuck_rdy, 0);
        chk("stuck_per_valid", {31'd0, per_mem_valid}, 32'd1);
        chk("pre_rst_bus_err", {31'd0, bus_err}, 32'd1);
        #2;
        rst_n = 1'b0;
        cpu_mem_valid = 1'b0;
        m_act = 1'b0; e_err = 1'b0; e_addr = '0;
        #1;
        chk("async_rst_per_valid", {31'd0, per_mem_valid}, 32'd0);
        chk("async_rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("async_rst_err_addr", bus_err_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(32'h0000_0010, '0, 4'b0000, 0, 1'b0, rd, lat);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_data", rd, 32'h1234_5678);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcu_subsys_bus_decoder.md
Name: mcu_subsys_bus_decoder

Overview:
Sits between the RISC-V core's native memory port and its slaves: on-chip SRAM and the peripheral register window (GNSS correlator/UART CSRs).
- Decodes each CPU request by address.
- Forwards the request to exactly one target through a registered stage.
- Returns rdata/ready to the CPU one cycle after the target completes.
- Unmapped accesses complete with an error word and set a sticky error flag.

Parameters:
SRAM_BASE, 32'h0000_0000, base of SRAM window (aligned to 2**SRAM_AW)
SRAM_AW, 16, log2 bytes of SRAM window
PERIPH_BASE, 32'h4000_0000, base of peripheral window (aligned to 2**PERIPH_AW)
PERIPH_AW, 16, log2 bytes of peripheral window
TIMEOUT_CYCLES, 255, max target wait cycles (used only with MCU_BUS_TIMEOUT_EN); range 1..65535

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_mem_valid  in  1  CPU request valid
cpu_mem_ready  out  1  CPU request complete, one-cycle pulse
cpu_mem_addr  in  32  CPU byte address
cpu_mem_wdata  in  32  CPU write data
cpu_mem_wstrb  in  4  byte write strobes; 0 = read
cpu_mem_rdata  out  32  read data, valid while cpu_mem_ready
sram_mem_valid / per_mem_valid  out  1  target request valid
sram_mem_ready / per_mem_ready  in  1  target ready
sram_mem_addr / per_mem_addr  out  32  offset within window: upper bits zero
sram_mem_wdata / per_mem_wdata  out  32  registered write data
sram_mem_wstrb / per_mem_wstrb  out  4  registered strobes
sram_mem_rdata / per_mem_rdata  in  32  target read data
bus_err  out  1  sticky error flag
bus_err_addr  out  32  address of first unacknowledged error
bus_err_clr  in  1  clears bus_err and bus_err_addr

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0: both target valids, cpu_mem_ready, cpu_mem_rdata, bus_err, bus_err_addr.
  - Reset mid-transaction abandons the access; target valid drops immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On cpu_mem_valid, register addr/wdata/wstrb and decoded target (SRAM, PERIPH, NONE).
  - SRAM/PERIPH -> ACCESS; NONE -> RESP with error.
- ACCESS:
  - Only the selected target's valid = 1, driven from registers; the other target's valid is 0.
  - When selected ready = 1: capture target rdata into the response register -> RESP.
  - Writes capture rdata too; the value is don't-care to the CPU.
- RESP:
  - cpu_mem_ready = 1 for exactly one cycle; cpu_mem_rdata = captured word; target valids 0 -> IDLE.
  - In this cycle, cpu_mem_valid is ignored; a new request is accepted only from IDLE.
- Latency: cpu_mem_valid sampled at edge N; with a zero-wait target (SRAM ready tied 1) cpu_mem_ready is high during cycle N+2. Each target wait cycle adds one cycle.
- Decode: hit when (addr & ~(2**AW-1)) == BASE.
  - Window check is on full 32 bits; SRAM has priority if windows overlap (misconfiguration).
  - Forwarded addr = addr[AW-1:0], zero-extended.
- Error response:
  - cpu_mem_rdata = 32'hDEAD_BEEF; writes are discarded.
  - bus_err set; bus_err_addr loaded only if bus_err was 0 (first error kept).
- bus_err_clr and a new error in the same cycle: the new error wins (flag stays set, address = new address).
- cpu_mem_ready and cpu_mem_rdata are registered outputs. rdata = 0 outside RESP.

Optional Feature:
MCU_BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on IDLE->ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES with ready still low: drop target valid and go to RESP with the error response (DEAD_BEEF, bus_err, bus_err_addr rules as above).
  - Ready arriving in the same cycle as the timeout: ready wins, normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package mcu_subsys_pkg:
  - state enum (IDLE/ACCESS/RESP)
  - target enum (TGT_NONE/TGT_SRAM/TGT_PERIPH)
  - BUS_ERR_RDATA = 32'hDEAD_BEEF
  - default window base/size constants
- Sub-module mcu_subsys_addr_decode (combinational, parameterised by the windows): addr -> target enum + offset. Reused by future DMA master.

Test Plan:
- SRAM read, ready tied 1, addr 0x0000_0010 with SRAM word 4 = 0x1234_5678 -> cpu_mem_ready at N+2, rdata 0x1234_5678, sram_mem_addr 0x10, per_mem_valid never asserted.
- SRAM byte write: wstrb 4'b0010, wdata 0xAABBCCDD to 0x20, then read 0x20 (prior word 0) -> 0x0000_CC00.
- Peripheral read with per_mem_ready delayed 3 cycles, addr 0x4000_0104 -> per_mem_addr 0x104; ready at N+5; rdata matches per_mem_rdata.
- Unmapped read 0x8000_0000 -> ready at N+1, rdata 0xDEAD_BEEF, bus_err=1, bus_err_addr 0x8000_0000. Second error at 0x9000_0000 keeps addr. bus_err_clr concurrent with a third error at 0xA000_0000 -> bus_err stays 1, addr 0xA000_0000.
- MCU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, per_mem_ready stuck 0 -> per_mem_valid drops after 8 ACCESS cycles, rdata DEAD_BEEF, bus_err=1. Without the macro the bench observes no ready within 100 cycles.
- rst_n pulsed low during ACCESS of a peripheral read -> all outputs 0 immediately. After release, the next SRAM read completes normally at N+2.
